// File: rtl/mpd_io_release_ctrl.sv
// mpd_io_release_ctrl
//   Qualifies a configuration-done signature, then releases IO banks one at a
//   time with a fixed gap, and finally reports fabric_done. An asynchronous
//   pad override forces immediate completion. A synchronous clear returns the
//   controller to IDLE. A free-running heartbeat drives an LED.
//
// Ports
//   CLK           : clock, rising-edge
//   resetn        : asynchronous active-low reset
//   cfg_sig       : configuration latch signature word (SIG_W bits)
//   done_override : asynchronous pad input, forces done
//   clear         : synchronous return-to-IDLE request
//   bank_en       : per-bank IO release enables (NUM_BANKS bits, monotonic)
//   fabric_done   : high exactly while in DONE
//   heart_led     : heartbeat counter MSB
//   state_o       : state encoding IDLE=0 QUAL=1 RELEASE=2 DONE=3
module mpd_io_release_ctrl #(
  parameter int              SIG_W         = 48,
  parameter logic [SIG_W-1:0] SIGNATURE    = 48'hFEEDBADCA77E,
  parameter int              STABLE_CYCLES = 16,
  parameter int              NUM_BANKS     = 4,
  parameter int              GAP_CYCLES    = 8,
  parameter int              HB_BITS       = 22
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic [SIG_W-1:0]     cfg_sig,
  input  logic                 done_override,
  input  logic                 clear,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic                 fabric_done,
  output logic                 heart_led,
  output logic [1:0]           state_o
);

  // Elaboration-time parameter range checks
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("mpd_io_release_ctrl: STABLE_CYCLES must be 1..255");
  end
  if (NUM_BANKS < 1 || NUM_BANKS > 16) begin : g_bad_banks
    $error("mpd_io_release_ctrl: NUM_BANKS must be 1..16");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("mpd_io_release_ctrl: GAP_CYCLES must be 1..255");
  end
  if (HB_BITS < 1 || SIG_W < 1) begin : g_bad_width
    $error("mpd_io_release_ctrl: HB_BITS and SIG_W must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUAL    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Terminal counter values: counters stop at these and never wrap.
  localparam logic [7:0]           QUAL_LAST  = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]           GAP_LAST   = 8'(GAP_CYCLES - 1);
  localparam logic [3:0]           LAST_IDX   = 4'(NUM_BANKS - 1);
  localparam logic [NUM_BANKS-1:0] FIRST_BANK = NUM_BANKS'(1'b1);
  localparam logic [NUM_BANKS-1:0] ALL_BANKS  = {NUM_BANKS{1'b1}};
  localparam logic [NUM_BANKS-1:0] NO_BANKS   = {NUM_BANKS{1'b0}};

  state_t               state_r, state_s;
  logic [7:0]           qual_cnt_r, qual_cnt_s;
  logic [7:0]           gap_cnt_r, gap_cnt_s;
  logic [3:0]           bank_idx_r, bank_idx_s, next_idx_s;
  logic [NUM_BANKS-1:0] bank_en_r, bank_en_s, next_bank_s;
  logic                 done_r;
  logic                 match_r;
  logic                 ovr_meta_r, ovr_sync_r;   // ovr_sync_r is ovr_s
  logic [HB_BITS-1:0]   hb_cnt_r;

  // Two-flop synchroniser for the asynchronous override pad
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      ovr_meta_r <= 1'b0;
      ovr_sync_r <= 1'b0;
    end else begin
      ovr_meta_r <= done_override;
      ovr_sync_r <= ovr_meta_r;
    end
  end

  // Registered signature compare, keeps the wide comparator off the FSM path
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      match_r <= 1'b0;
    end else begin
      match_r <= (cfg_sig == SIGNATURE);
    end
  end

  // Free-running heartbeat; clear deliberately does not touch it
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      hb_cnt_r <= {HB_BITS{1'b0}};
    end else begin
      hb_cnt_r <= hb_cnt_r + {{(HB_BITS-1){1'b0}}, 1'b1};
    end
  end

  // One-hot mask of the bank that the next gap expiry will enable
  always_comb begin
    next_idx_s  = bank_idx_r + 4'd1;
    next_bank_s = NO_BANKS;
    for (int i = 0; i < NUM_BANKS; i++) begin
      next_bank_s[i] = (4'(i) == next_idx_s);
    end
  end

  // Next-state logic: override beats clear, clear beats normal sequencing
  always_comb begin
    state_s    = state_r;
    qual_cnt_s = qual_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    bank_idx_s = bank_idx_r;
    bank_en_s  = bank_en_r;
    if (ovr_sync_r) begin
      state_s    = ST_DONE;
      bank_en_s  = ALL_BANKS;
      qual_cnt_s = 8'd0;
      gap_cnt_s  = 8'd0;
      bank_idx_s = 4'd0;
    end else if (clear) begin
      state_s    = ST_IDLE;
      bank_en_s  = NO_BANKS;
      qual_cnt_s = 8'd0;
      gap_cnt_s  = 8'd0;
      bank_idx_s = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (match_r && (QUAL_LAST == 8'd0)) begin
            // A single matching cycle already satisfies qualification
            state_s    = (NUM_BANKS == 1) ? ST_DONE : ST_RELEASE;
            bank_en_s  = bank_en_r | FIRST_BANK;
            qual_cnt_s = 8'd0;
            gap_cnt_s  = 8'd0;
            bank_idx_s = 4'd0;
          end else if (match_r) begin
            state_s    = ST_QUAL;
            qual_cnt_s = 8'd1;
          end else begin
            qual_cnt_s = 8'd0;
          end
        end
        ST_QUAL: begin
          if (!match_r) begin
            state_s    = ST_IDLE;
            qual_cnt_s = 8'd0;
          end else if (qual_cnt_r == QUAL_LAST) begin
            // This edge counts the final required matching cycle
            state_s    = (NUM_BANKS == 1) ? ST_DONE : ST_RELEASE;
            bank_en_s  = bank_en_r | FIRST_BANK;
            qual_cnt_s = 8'd0;
            gap_cnt_s  = 8'd0;
            bank_idx_s = 4'd0;
          end else begin
            qual_cnt_s = qual_cnt_r + 8'd1;
          end
        end
        ST_RELEASE: begin
          // match_r is ignored here: release progress is sticky
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_s  = 8'd0;
            bank_idx_s = next_idx_s;
            bank_en_s  = bank_en_r | next_bank_s;
            if (next_idx_s == LAST_IDX) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_RELEASE;
            end
          end else begin
            gap_cnt_s = gap_cnt_r + 8'd1;
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s    = ST_IDLE;
          bank_en_s  = NO_BANKS;
          qual_cnt_s = 8'd0;
          gap_cnt_s  = 8'd0;
          bank_idx_s = 4'd0;
        end
      endcase
    end
  end

  // FSM, counter and output registers
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      qual_cnt_r <= 8'd0;
      gap_cnt_r  <= 8'd0;
      bank_idx_r <= 4'd0;
      bank_en_r  <= NO_BANKS;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      qual_cnt_r <= qual_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      bank_idx_r <= bank_idx_s;
      bank_en_r  <= bank_en_s;
      done_r     <= (state_s == ST_DONE);
    end
  end

  assign bank_en     = bank_en_r;
  assign fabric_done = done_r;
  assign heart_led   = hb_cnt_r[HB_BITS-1];
  assign state_o     = state_r;

endmodule

// File: tb/tb_mpd_io_release_ctrl.sv
// Testbench for mpd_io_release_ctrl. Three instances share stimulus:
//   a: defaults, b: HB_BITS=4, c: NUM_BANKS=1 STABLE_CYCLES=1 HB_BITS=5.
// Each posedge a reference model predicts the post-edge outputs and pushes
// them into per-instance queues; a negedge monitor pops and compares.
module tb_mpd_io_release_ctrl;

  localparam logic [47:0] SIG = 48'hFEEDBADCA77E;
  localparam int STB [3] = '{16, 16, 1};
  localparam int NB  [3] = '{4, 4, 1};
  localparam int GP  [3] = '{8, 8, 8};
  localparam int HBW [3] = '{22, 4, 5};

  logic        CLK;
  logic        resetn;
  logic [47:0] cfg_sig;
  logic        done_override;
  logic        clear;

  logic [3:0] a_bank, b_bank;
  logic [0:0] c_bank;
  logic       a_done, b_done, c_done;
  logic       a_led, b_led, c_led;
  logic [1:0] a_state, b_state, c_state;

  mpd_io_release_ctrl dut_a (
    .CLK(CLK), .resetn(resetn), .cfg_sig(cfg_sig), .done_override(done_override),
    .clear(clear), .bank_en(a_bank), .fabric_done(a_done), .heart_led(a_led),
    .state_o(a_state)
  );

  mpd_io_release_ctrl #(.HB_BITS(4)) dut_b (
    .CLK(CLK), .resetn(resetn), .cfg_sig(cfg_sig), .done_override(done_override),
    .clear(clear), .bank_en(b_bank), .fabric_done(b_done), .heart_led(b_led),
    .state_o(b_state)
  );

  mpd_io_release_ctrl #(.NUM_BANKS(1), .STABLE_CYCLES(1), .HB_BITS(5)) dut_c (
    .CLK(CLK), .resetn(resetn), .cfg_sig(cfg_sig), .done_override(done_override),
    .clear(clear), .bank_en(c_bank), .fabric_done(c_done), .heart_led(c_led),
    .state_o(c_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: actual %h required %h", nm, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  // run: consecutive matching cycles counted; rel: edges since first bank
  // release (-1 if not releasing); dn: done; banks: number of banks enabled.
  int run_m [3], rel_m [3], banks_m [3], hb_m [3];
  bit dn_m [3], mq_m [3], s1_m [3], s2_m [3];
  logic [7:0] q0 [$], q1 [$], q2 [$];

  function automatic logic [7:0] exp_of(int i);
    logic [3:0] b;
    logic [1:0] s;
    logic       l;
    b = 4'((1 << banks_m[i]) - 1);
    if (dn_m[i]) s = 2'd3;
    else if (rel_m[i] >= 0) s = 2'd2;
    else if (run_m[i] > 0) s = 2'd1;
    else s = 2'd0;
    l = ((hb_m[i] >> (HBW[i] - 1)) & 1) != 0;
    return {b, dn_m[i], s, l};
  endfunction

  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (!resetn) begin
        run_m[i] = 0; rel_m[i] = -1; banks_m[i] = 0; hb_m[i] = 0;
        dn_m[i] = 0; mq_m[i] = 0; s1_m[i] = 0; s2_m[i] = 0;
      end else begin
        if (s2_m[i]) begin
          dn_m[i] = 1; banks_m[i] = NB[i]; rel_m[i] = -1; run_m[i] = 0;
        end else if (clear) begin
          dn_m[i] = 0; banks_m[i] = 0; rel_m[i] = -1; run_m[i] = 0;
        end else if (dn_m[i]) begin
          dn_m[i] = 1;
        end else if (rel_m[i] >= 0) begin
          rel_m[i]++;
          banks_m[i] = 1 + rel_m[i] / GP[i];
          if (banks_m[i] >= NB[i]) begin banks_m[i] = NB[i]; dn_m[i] = 1; end
        end else if (mq_m[i]) begin
          run_m[i]++;
          if (run_m[i] == STB[i]) begin
            run_m[i] = 0; rel_m[i] = 0; banks_m[i] = 1;
            if (NB[i] == 1) dn_m[i] = 1;
          end
        end else begin
          run_m[i] = 0;
        end
        hb_m[i] = (hb_m[i] + 1) & ((1 << HBW[i]) - 1);
        s2_m[i] = s1_m[i];
        s1_m[i] = done_override;
        mq_m[i] = (cfg_sig == SIG);
      end
    end
    q0.push_back(exp_of(0));
    q1.push_back(exp_of(1));
    q2.push_back(exp_of(2));
  end

  // ---------------- monitor ----------------
  logic [7:0] e0, e1, e2;
  always @(negedge CLK) begin
    if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
      chk("scoreboard_underflow", 16'd0, 16'd1);
    end else begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      chk("sb_a", {8'd0, a_bank, a_done, a_state, a_led}, {8'd0, e0});
      chk("sb_b", {8'd0, b_bank, b_done, b_state, b_led}, {8'd0, e1});
      chk("sb_c", {8'd0, 3'd0, c_bank, c_done, c_state, c_led}, {8'd0, e2});
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  // ---------------- stimulus ----------------
  int nb_exp;
  int seg;
  bit sig_mode;
  bit found;

  initial begin
    resetn = 1'b0; cfg_sig = 48'd0; done_override = 1'b0; clear = 1'b0;
    tick();
    chk("reset_state", {a_bank, a_done, a_state, a_led, c_bank, c_done}, 16'd0);

    // Signature held from cycle 0: banks at edges 17/25/33/41, done at 41
    resetn = 1'b1; cfg_sig = SIG;
    for (int e = 1; e <= 45; e++) begin
      tick();
      nb_exp = (e < 17) ? 0 : ((1 + (e - 17) / 8 > 4) ? 4 : 1 + (e - 17) / 8);
      chk("s1_bank_a", {12'd0, a_bank}, 16'((1 << nb_exp) - 1));
      chk("s1_done_a", {15'd0, a_done}, {15'd0, e >= 41});
      chk("s1_done_c", {14'd0, c_bank, c_done}, (e >= 2) ? 16'd3 : 16'd0);
    end

    // Async reset while in DONE; heartbeat restarts
    #2 resetn = 1'b0;
    #1 chk("rst_async", {7'd0, a_bank, a_done, a_state, a_led, b_led, c_done}, 16'd0);
    tick();
    resetn = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      chk("hb_b_led", {15'd0, b_led}, 16'((e / 8) % 2));
      if (e == 16) chk("requal_e16", {12'd0, a_bank}, 16'd0);
      if (e == 17) chk("requal_e17", {12'd0, a_bank}, 16'd1);
    end

    // Signature glitch during qualification
    clear = 1'b1; cfg_sig = 48'd0;
    tick();
    clear = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      cfg_sig = (e == 11) ? 48'd0 : SIG;
      tick();
      if (e == 11) chk("glitch_e11_state", {14'd0, a_state}, 16'd1);
      if (e == 12) chk("glitch_e12_state", {14'd0, a_state}, 16'd0);
      if (e == 13) chk("glitch_e13_state", {14'd0, a_state}, 16'd1);
      if (e == 27) chk("glitch_e27_bank", {12'd0, a_bank}, 16'd0);
      if (e == 28) chk("glitch_e28_bank", {12'd0, a_bank}, 16'd1);
    end

    // Override pulse during QUAL
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      done_override = (e >= 6 && e <= 8);
      tick();
      if (e == 7) chk("ovr_e7_state", {14'd0, a_state}, 16'd1);
      if (e == 8) chk("ovr_e8", {11'd0, a_bank, a_done}, 16'h1F);
      if (e == 20) chk("ovr_sticky", {9'd0, a_bank, a_done, a_state}, 16'h7F);
    end

    // Clear during RELEASE after bank 1, then clear+override together
    clear = 1'b1;
    tick();
    clear = 1'b0;
    found = 1'b0;
    for (int e = 0; e < 60 && !found; e++) begin
      tick();
      if (a_bank == 4'h3) found = 1'b1;
    end
    chk("reach_bank1", {15'd0, found}, 16'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_release", {10'd0, a_bank, a_state}, 16'd0);
    clear = 1'b1; done_override = 1'b1;
    tick(); tick(); tick();
    chk("clear_ovr_win", {9'd0, a_bank, a_done, a_state}, 16'h7F);
    clear = 1'b0; done_override = 1'b0;
    tick(); tick(); tick();
    chk("ovr_release_sticky", {13'd0, a_done, a_state}, 16'h7);

    // Randomized phase
    clear = 1'b1;
    tick();
    seg = 0;
    for (int n = 0; n < 3000; n++) begin
      #2;
      if (seg == 0) begin
        seg = $urandom_range(60, 1);
        sig_mode = ($urandom_range(3, 0) != 0);
      end
      seg--;
      if (sig_mode) cfg_sig = SIG;
      else if ($urandom_range(1, 0) == 1) cfg_sig = SIG ^ (48'd1 << $urandom_range(47, 0));
      else cfg_sig = 48'({$urandom, $urandom});
      done_override = ($urandom_range(299, 0) == 0);
      clear = ($urandom_range(199, 0) == 0);
      resetn = ($urandom_range(499, 0) != 0);
      tick();
    end
    resetn = 1'b1; clear = 1'b0; done_override = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mpd_io_release_ctrl.md
MPD_IO_RELEASE_CTRL -- requirements
Module: mpd_io_release_ctrl

Interface
REQ-001 SHALL have parameter SIG_W, default 48: width of the configuration signature word.
REQ-002 SHALL have parameter SIGNATURE, default 48'hFEEDBADCA77E: magic value that qualifies configuration done.
REQ-003 SHALL have parameter STABLE_CYCLES, default 16: number of consecutive matching cycles required before release; legal range 1..255.
REQ-004 SHALL have parameter NUM_BANKS, default 4: number of IO banks released in sequence; legal range 1..16.
REQ-005 SHALL have parameter GAP_CYCLES, default 8: cycles between successive bank releases; legal range 1..255.
REQ-006 SHALL have parameter HB_BITS, default 22: heartbeat counter width.
REQ-007 SHALL have port CLK, input, 1 bit: the single clock; all flops are clocked on its rising edge.
REQ-008 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port cfg_sig, input, SIG_W bits: configuration latch signature word.
REQ-010 SHALL have port done_override, input, 1 bit: asynchronous pad input that forces done.
REQ-011 SHALL have port clear, input, 1 bit: synchronous request to return to IDLE.
REQ-012 SHALL have port bank_en, output, NUM_BANKS bits: per-bank IO release enables.
REQ-013 SHALL have port fabric_done, output, 1 bit: configuration complete.
REQ-014 SHALL have port heart_led, output, 1 bit: heartbeat output.
REQ-015 SHALL have port state_o, output, 2 bits: current state encoding.

Function
REQ-016 SHALL register match_q = (cfg_sig == SIGNATURE) every cycle.
REQ-017 SHALL pass done_override through a 2-flop synchroniser; ovr_s denotes the synchroniser output.
REQ-018 SHALL implement states IDLE=0, QUAL=1, RELEASE=2, DONE=3, reflected directly on state_o.
REQ-019 IDLE: SHALL move to QUAL when match_q=1, with qual_cnt set to 1.
REQ-020 QUAL: SHALL increment qual_cnt on each cycle with match_q=1 and return to IDLE with qual_cnt=0 on any cycle with match_q=0.
REQ-021 QUAL: SHALL enter RELEASE, and set bank_en[0] on the same edge, once STABLE_CYCLES consecutive match_q=1 cycles have been counted; if NUM_BANKS=1, SHALL enter DONE directly instead.
REQ-022 RELEASE: SHALL set bank_en[k] exactly GAP_CYCLES edges after bank_en[k-1], using gap_cnt and a bank index counter.
REQ-023 RELEASE: SHALL enter DONE on the same edge that the last bank_en bit rises.
REQ-024 bank_en bits SHALL be monotonic (never cleared) in RELEASE and DONE.
REQ-025 In RELEASE and DONE, loss of match_q SHALL be ignored (done is sticky).
REQ-026 fabric_done SHALL equal 1 if and only if state=DONE.
REQ-027 ovr_s=1 in any state SHALL force, on the next edge, state=DONE, bank_en set to all ones, and all counters cleared.
REQ-028 Deasserting ovr_s SHALL have no effect; DONE persists.
REQ-029 clear=1 with ovr_s=0 SHALL, on the next edge, force state=IDLE, bank_en=0, and all counters to 0, from any state.
REQ-030 When clear=1 and ovr_s=1 together, override SHALL win.
REQ-031 After clear is released, a fresh qualification SHALL be required.
REQ-032 SHALL run a free-running HB_BITS heartbeat counter that increments every cycle, wraps from all-ones to 0, and is unaffected by clear; heart_led = counter MSB.
REQ-033 SHALL size qual_cnt and gap_cnt at 8 bits and never let them exceed their parameter values (no wrap).
REQ-034 SHALL trigger an elaboration error if any parameter is out of its legal range.

Reset
REQ-035 resetn=0 SHALL immediately set state=IDLE, bank_en=0, fabric_done=0, heart_led=0, state_o=0, clear all counters, match_q=0, and both synchroniser flops to 0.
REQ-036 Reset asserted mid-RELEASE or in DONE SHALL discard all progress; after release, full requalification is required.

Verification
REQ-037 Bench SHALL cover: cfg_sig=SIGNATURE held from cycle 0 with defaults -> bank_en[0] rises at edge 17, bank_en[1..3] at edges 25/33/41, and fabric_done rises at edge 41.
REQ-038 Bench SHALL cover: signature held for 10 cycles, dropped for 1, then held -> return to IDLE, qualification restarts, and bank_en[0] rises 17 edges after the second match begins.
REQ-039 Bench SHALL cover: done_override pulsed high for 3 cycles during QUAL -> bank_en=4'hF and fabric_done=1 within 3 edges, staying high after the pulse.
REQ-040 Bench SHALL cover: clear pulsed during RELEASE, after bank 1 -> next edge state_o=0 and bank_en=0; clear and override high together -> DONE.
REQ-041 Bench SHALL cover: resetn low for 1 cycle while in DONE -> all outputs 0 asynchronously, and the heartbeat restarts from 0 (with HB_BITS=4, heart_led toggles every 8 cycles).
REQ-042 Bench SHALL cover: NUM_BANKS=1, STABLE_CYCLES=1 -> DONE and bank_en=1 at edge 2 after the match.
